decode_stage: RTL and testbench

Pipeline stage directly downstream of fetch. Captures the fetch outputs (instrF, PCF, PCPlus4F) in an IF/ID register and decodes RV32I instructions. Reads the 32x32 register file and generates the immediate and control signals. Results are registered into an ID/EX register for the execute stage; the register file write port comes from writeback.

---
 rtl/decode_stage.sv | 198 +++++++++++++++++++
 tb/tb_decode_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, 32x32 register file, immediate/control decode, ID/EX register.
// Optional macro REGFILE_BYPASS_EN makes the read ports write-through for same-cycle writeback.
module decode_stage #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallD,
  input  logic                  FlushD,
  input  logic                  FlushE,
  input  logic [31:0]           instrF,
  input  logic [DATA_WIDTH-1:0] PCF,
  input  logic [DATA_WIDTH-1:0] PCPlus4F,
  input  logic                  RegWriteW,
  input  logic [4:0]            RdW,
  input  logic [DATA_WIDTH-1:0] ResultW,
  output logic [4:0]            Rs1D,
  output logic [4:0]            Rs2D,
  output logic [DATA_WIDTH-1:0] RD1E,
  output logic [DATA_WIDTH-1:0] RD2E,
  output logic [DATA_WIDTH-1:0] ImmExtE,
  output logic [DATA_WIDTH-1:0] PCE,
  output logic [DATA_WIDTH-1:0] PCPlus4E,
  output logic [4:0]            Rs1E,
  output logic [4:0]            Rs2E,
  output logic [4:0]            RdE,
  output logic                  RegWriteE,
  output logic                  MemWriteE,
  output logic                  JumpE,
  output logic                  BranchE,
  output logic                  ALUSrcE,
  output logic                  JALRinstrE,
  output logic [1:0]            ResultSrcE,
  output logic [3:0]            ALUControlE,
  output logic [2:0]            Funct3E
);

  localparam logic [3:0] ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4, ALU_SLT = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8, ALU_SLTU = 4'd9, ALU_PASSB = 4'd10;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]            rs1, rs2, rd;
    logic                  regwrite, memwrite, jump, branch, alusrc, jalr;
    logic [1:0]            resultsrc;
    logic [3:0]            aluctl;
    logic [2:0]            funct3;
  } idex_t;

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  logic [31:0]           instrD_q;
  logic [DATA_WIDTH-1:0] pcD_q, pc4D_q;
  logic [DATA_WIDTH-1:0] rf_q [31:1];
  logic [DATA_WIDTH-1:0] rd1_d, rd2_d;
  idex_t                 idex_d, idex_q;

  // IF/ID boundary: a flush also clears the PCs so a NOP never carries a stale PC.
  always_ff @(posedge clk) begin
    if (rst || FlushD) begin
      instrD_q <= NOP_INSTR;
      pcD_q    <= '0;
      pc4D_q   <= '0;
    end else if (!StallD) begin
      instrD_q <= instrF;
      pcD_q    <= PCF;
      pc4D_q   <= PCPlus4F;
    end
  end

  assign Rs1D = instrD_q[19:15];
  assign Rs2D = instrD_q[24:20];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) rf_q[i] <= '0;
    end else if (RegWriteW && (RdW != 5'd0)) begin
      rf_q[RdW] <= ResultW;
    end
  end

  always_comb begin
    rd1_d = (Rs1D == 5'd0) ? '0 : rf_q[Rs1D];
    rd2_d = (Rs2D == 5'd0) ? '0 : rf_q[Rs2D];
`ifdef REGFILE_BYPASS_EN
    if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1D)) rd1_d = ResultW;
    if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2D)) rd2_d = ResultW;
`else
`endif
  end

  always_comb begin
    idex_d        = '0;
    idex_d.rd1    = rd1_d;
    idex_d.rd2    = rd2_d;
    idex_d.pc     = pcD_q;
    idex_d.pc4    = pc4D_q;
    idex_d.rs1    = Rs1D;
    idex_d.rs2    = Rs2D;
    idex_d.rd     = instrD_q[11:7];
    idex_d.funct3 = instrD_q[14:12];
    case (instrD_q[6:0])
      7'b0110011: begin
        idex_d.regwrite = 1'b1;
        idex_d.aluctl   = alu_op(instrD_q[14:12], instrD_q[30]);
      end
      7'b0010011: begin
        // Only srai honours bit 30; addi with imm[10]=1 stays an add.
        idex_d.regwrite = 1'b1;
        idex_d.alusrc   = 1'b1;
        idex_d.aluctl   = alu_op(instrD_q[14:12], instrD_q[30] && (instrD_q[14:12] == 3'b101));
        idex_d.imm      = DATA_WIDTH'($signed(instrD_q[31:20]));
      end
      7'b0000011: begin
        idex_d.regwrite  = 1'b1;
        idex_d.alusrc    = 1'b1;
        idex_d.resultsrc = 2'b01;
        idex_d.imm       = DATA_WIDTH'($signed(instrD_q[31:20]));
      end
      7'b0100011: begin
        idex_d.memwrite = 1'b1;
        idex_d.alusrc   = 1'b1;
        idex_d.imm      = DATA_WIDTH'($signed({instrD_q[31:25], instrD_q[11:7]}));
      end
      7'b1100011: begin
        idex_d.branch = 1'b1;
        idex_d.aluctl = ALU_SUB;
        idex_d.imm    = DATA_WIDTH'($signed({instrD_q[31], instrD_q[7], instrD_q[30:25],
                                              instrD_q[11:8], 1'b0}));
      end
      7'b1101111: begin
        idex_d.regwrite  = 1'b1;
        idex_d.jump      = 1'b1;
        idex_d.resultsrc = 2'b10;
        idex_d.imm       = DATA_WIDTH'($signed({instrD_q[31], instrD_q[19:12], instrD_q[20],
                                               instrD_q[30:21], 1'b0}));
      end
      7'b1100111: begin
        idex_d.regwrite  = 1'b1;
        idex_d.jump      = 1'b1;
        idex_d.jalr      = 1'b1;
        idex_d.resultsrc = 2'b10;
        idex_d.alusrc    = 1'b1;
        idex_d.imm       = DATA_WIDTH'($signed(instrD_q[31:20]));
      end
      7'b0110111: begin
        idex_d.regwrite = 1'b1;
        idex_d.alusrc   = 1'b1;
        idex_d.aluctl   = ALU_PASSB;
        idex_d.imm      = DATA_WIDTH'($signed({instrD_q[31:12], 12'b0}));
      end
      7'b0010111: begin
        idex_d.regwrite = 1'b1;
        idex_d.alusrc   = 1'b1;
        idex_d.imm      = DATA_WIDTH'($signed({instrD_q[31:12], 12'b0}));
      end
      default: ;
    endcase
  end

  // ID/EX boundary: stall does not hold this register; the hazard unit pairs it with FlushE.
  always_ff @(posedge clk) begin
    if (rst || FlushE) idex_q <= '0;
    else               idex_q <= idex_d;
  end

  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc4;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;
  assign RdE         = idex_q.rd;
  assign RegWriteE   = idex_q.regwrite;
  assign MemWriteE   = idex_q.memwrite;
  assign JumpE       = idex_q.jump;
  assign BranchE     = idex_q.branch;
  assign ALUSrcE     = idex_q.alusrc;
  assign JALRinstrE  = idex_q.jalr;
  assign ResultSrcE  = idex_q.resultsrc;
  assign ALUControlE = idex_q.aluctl;
  assign Funct3E     = idex_q.funct3;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic vs a cycle model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, StallD, FlushD, FlushE, RegWriteW;
  logic [31:0] instrF, PCF, PCPlus4F, ResultW;
  logic [4:0]  RdW;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JALRinstrE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic [2:0]  Funct3E;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .instrF(instrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .JALRinstrE(JALRinstrE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .Funct3E(Funct3E)
  );

  wire [189:0] obs = {RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE,
                      RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JALRinstrE,
                      ResultSrcE, ALUControlE, Funct3E};

  // Reference model state
  logic [31:0]  m_regs [32];
  logic [31:0]  m_instr, m_pc, m_pc4;
  logic [189:0] m_e;

  // funct3 -> ALU code: add sll slt sltu xor srl or and
  localparam logic [3:0] ALU_TAB [8] = '{4'd0, 4'd6, 4'd5, 4'd9, 4'd4, 4'd7, 4'd3, 4'd2};
  localparam logic [6:0] OPS [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                      7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};

  function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic alt);
    if (alt && f3 == 3'd0) return 4'd1;
    if (alt && f3 == 3'd5) return 4'd8;
    return ALU_TAB[f3];
  endfunction

  function automatic logic [31:0] sx(input int unsigned v, input int bits);
    int s;
    s = int'(v << (32 - bits)) >>> (32 - bits);
    return 32'(s);
  endfunction

  function automatic logic [189:0] decode_ref(input logic [31:0] i, pc, pc4, a, b);
    logic rw, mw, j, br, as, jr;
    logic [1:0] rs;
    logic [3:0] alu;
    logic [31:0] imm;
    rw = 0; mw = 0; j = 0; br = 0; as = 0; jr = 0; rs = 2'd0; alu = 4'd0; imm = 32'd0;
    case (i[6:0])
      7'h33: begin rw = 1; alu = alu_ref(i[14:12], i[30]); end
      7'h13: begin rw = 1; as = 1; alu = alu_ref(i[14:12], i[30] && i[14:12] == 3'd5);
                   imm = sx(i[31:20], 12); end
      7'h03: begin rw = 1; as = 1; rs = 2'd1; imm = sx(i[31:20], 12); end
      7'h23: begin mw = 1; as = 1; imm = sx({i[31:25], i[11:7]}, 12); end
      7'h63: begin br = 1; alu = 4'd1;
                   imm = sx({i[31], i[7], i[30:25], i[11:8], 1'b0}, 13); end
      7'h6F: begin rw = 1; j = 1; rs = 2'd2;
                   imm = sx({i[31], i[19:12], i[20], i[30:21], 1'b0}, 21); end
      7'h67: begin rw = 1; j = 1; jr = 1; rs = 2'd2; as = 1; imm = sx(i[31:20], 12); end
      7'h37: begin rw = 1; as = 1; alu = 4'd10; imm = i & 32'hFFFFF000; end
      7'h17: begin rw = 1; as = 1; imm = i & 32'hFFFFF000; end
      default: ;
    endcase
    return {a, b, imm, pc, pc4, i[19:15], i[24:20], i[11:7], rw, mw, j, br, as, jr, rs, alu, i[14:12]};
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (RegWriteW && RdW == idx) return ResultW;
`endif
    return m_regs[idx];
  endfunction

  task automatic model_update();
    logic [31:0] a, b;
    a = rd_model(m_instr[19:15]);
    b = rd_model(m_instr[24:20]);
    if (rst || FlushE) m_e = '0;
    else               m_e = decode_ref(m_instr, m_pc, m_pc4, a, b);
    if (rst || FlushD) begin
      m_instr = 32'h00000013; m_pc = 32'd0; m_pc4 = 32'd0;
    end else if (!StallD) begin
      m_instr = instrF; m_pc = PCF; m_pc4 = PCPlus4F;
    end
    if (rst) begin
      for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
    end else if (RegWriteW && RdW != 5'd0) begin
      m_regs[RdW] = ResultW;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_instr(input logic [31:0] ins);
    instrF   = ins;
    PCF      = $urandom & 32'hFFFFFFFC;
    PCPlus4F = PCF + 32'd4;
  endtask

  task automatic test_reset();
    rst = 1; StallD = 0; FlushD = 0; FlushE = 0; RegWriteW = 1; RdW = 5'd3; ResultW = 32'h55;
    set_instr($urandom);
    step(); step();
    n_cmp++; if (obs !== '0) begin n_err++; $display("FAIL reset_e: got %h expected 0", obs); end
    n_cmp++; if ({Rs1D, Rs2D} !== 10'd0) begin n_err++; $display("FAIL reset_rs: got %h expected 0", {Rs1D, Rs2D}); end
    rst = 0; RegWriteW = 0;
    set_instr(32'h00000013);
    step(); step();
    n_cmp++; if (obs !== m_e) begin n_err++; $display("FAIL nop_e: got %h expected %h", obs, m_e); end
    n_cmp++;
    if ({RegWriteE, RdE, ALUControlE, ImmExtE} !== {1'b1, 5'd0, 4'd0, 32'd0}) begin
      n_err++; $display("FAIL nop_fields: got %h expected %h", {RegWriteE, RdE, ALUControlE, ImmExtE}, {1'b1, 5'd0, 4'd0, 32'd0});
    end
  endtask

  task automatic test_bypass();
    logic [31:0] want;
`ifdef REGFILE_BYPASS_EN
    want = 32'h1234;
`else
    want = 32'h0;
`endif
    set_instr(32'hFFF38413);
    step();
    RegWriteW = 1; RdW = 5'd7; ResultW = 32'h1234;
    set_instr(32'h00000013);
    step();
    RegWriteW = 0;
    n_cmp++; if (RD1E !== want) begin n_err++; $display("FAIL bypass_rd1: got %h expected %h", RD1E, want); end
    n_cmp++; if (ImmExtE !== 32'hFFFFFFFF) begin n_err++; $display("FAIL bypass_imm: got %h expected ffffffff", ImmExtE); end
    n_cmp++; if (obs !== m_e) begin n_err++; $display("FAIL bypass_e: got %h expected %h", obs, m_e); end
  endtask

  task automatic test_regfile();
    RegWriteW = 1; RdW = 5'd5; ResultW = 32'hDEADBEEF;
    set_instr(32'h00528333);
    step();
    RegWriteW = 0;
    set_instr(32'h00000013);
    step();
    n_cmp++;
    if ({RD1E, RD2E, RdE, RegWriteE, ALUSrcE} !== {32'hDEADBEEF, 32'hDEADBEEF, 5'd6, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL add_x6: got %h expected %h", {RD1E, RD2E, RdE, RegWriteE, ALUSrcE},
                        {32'hDEADBEEF, 32'hDEADBEEF, 5'd6, 1'b1, 1'b0});
    end
    n_cmp++; if (obs !== m_e) begin n_err++; $display("FAIL add_e: got %h expected %h", obs, m_e); end
  endtask

  task automatic test_branch_jalr();
    set_instr(32'hFE208EE3);
    step();
    set_instr(32'h000100E7);
    step();
    n_cmp++;
    if ({BranchE, ALUControlE, Funct3E, ImmExtE} !== {1'b1, 4'b0001, 3'b000, 32'hFFFFFFFC}) begin
      n_err++; $display("FAIL beq: got %h expected %h", {BranchE, ALUControlE, Funct3E, ImmExtE},
                        {1'b1, 4'b0001, 3'b000, 32'hFFFFFFFC});
    end
    set_instr(32'h00000013);
    step();
    n_cmp++;
    if ({JumpE, JALRinstrE, ResultSrcE} !== {1'b1, 1'b1, 2'b10}) begin
      n_err++; $display("FAIL jalr: got %h expected %h", {JumpE, JALRinstrE, ResultSrcE}, 4'b1110);
    end
    n_cmp++; if (obs !== m_e) begin n_err++; $display("FAIL jalr_e: got %h expected %h", obs, m_e); end
  endtask

  task automatic test_x0_unknown();
    RegWriteW = 1; RdW = 5'd0; ResultW = 32'd5;
    set_instr(32'h00000493);
    step();
    set_instr(32'h0000007F);
    step();
    RegWriteW = 0;
    n_cmp++; if (RD1E !== 32'd0) begin n_err++; $display("FAIL x0_read: got %h expected 0", RD1E); end
    set_instr(32'h00000013);
    step();
    n_cmp++;
    if ({RegWriteE, MemWriteE, JumpE, BranchE} !== 4'd0) begin
      n_err++; $display("FAIL unknown_op: got %b expected 0000", {RegWriteE, MemWriteE, JumpE, BranchE});
    end
    n_cmp++; if (obs !== m_e) begin n_err++; $display("FAIL unknown_e: got %h expected %h", obs, m_e); end
  endtask

  task automatic test_stall_flush();
    set_instr(32'h00528333);
    step();
    StallD = 1; FlushE = 1;
    for (int c = 0; c < 3; c++) begin
      set_instr($urandom);
      step();
      n_cmp++;
      if ({Rs1D, Rs2D} !== {5'd5, 5'd5}) begin
        n_err++; $display("FAIL stall_hold: got %h expected %h", {Rs1D, Rs2D}, {5'd5, 5'd5});
      end
      n_cmp++;
      if (obs[14:0] !== 15'd0) begin n_err++; $display("FAIL stall_bubble: got %h expected 0", obs[14:0]); end
    end
    FlushD = 1; FlushE = 0;
    step();
    n_cmp++; if ({Rs1D, Rs2D} !== 10'd0) begin n_err++; $display("FAIL flushd_nop: got %h expected 0", {Rs1D, Rs2D}); end
    StallD = 0; FlushD = 0;
    set_instr($urandom);
    step();
    n_cmp++;
    if ({RegWriteE, RdE, ALUSrcE, ImmExtE} !== {1'b1, 5'd0, 1'b1, 32'd0}) begin
      n_err++; $display("FAIL flushd_decode: got %h expected %h", {RegWriteE, RdE, ALUSrcE, ImmExtE}, {1'b1, 5'd0, 1'b1, 32'd0});
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      StallD    = ($urandom % 8) == 0;
      FlushD    = ($urandom % 12) == 0;
      FlushE    = StallD || (($urandom % 12) == 0);
      RegWriteW = $urandom % 2;
      RdW       = 5'($urandom);
      ResultW   = $urandom;
      set_instr({25'($urandom >> 7), OPS[$urandom % 10]});
      step();
      n_cmp++; if (obs !== m_e) begin n_err++; $display("FAIL rand_e[%0d]: got %h expected %h", c, obs, m_e); end
      n_cmp++;
      if ({Rs1D, Rs2D} !== {m_instr[19:15], m_instr[24:20]}) begin
        n_err++; $display("FAIL rand_rsd[%0d]: got %h expected %h", c, {Rs1D, Rs2D}, {m_instr[19:15], m_instr[24:20]});
      end
    end
    StallD = 0; FlushD = 0; FlushE = 0; RegWriteW = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; StallD = 0; FlushD = 0; FlushE = 0; RegWriteW = 0; RdW = 0; ResultW = 0;
    instrF = 32'h13; PCF = 0; PCPlus4F = 0;
    #2;
    test_reset();
    test_bypass();
    test_regfile();
    test_branch_jalr();
    test_x0_unknown();
    test_stall_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
